// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: load funct3 encodings, write-back state type and
// the load legality rule shared by the write-back path.
package rv32_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef enum logic {
      IDLE,
      LOAD_WAIT
   } wb_state_t;

   // True when a load must be refused: illegal funct3 or misaligned address.
   function automatic logic load_rejected(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic bad;
      case (funct3)
         F3_LB, F3_LBU: bad = 1'b0;
         F3_LH, F3_LHU: bad = addr_lo[0];
         F3_LW:         bad = (addr_lo != 2'd0);
         default:       bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it
// according to the load type.
module load_extend
   import rv32_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_field;
   logic [15:0] half_field;

   always_comb begin
      byte_field = rdata[{addr_lo, 3'b000} +: 8];
      half_field = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{byte_field[7]}}, byte_field};
         F3_LH:   data = {{16{half_field[15]}}, half_field};
         F3_LBU:  data = {24'd0, byte_field};
         F3_LHU:  data = {16'd0, half_field};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_load_unit.sv
// RV32I write-back stage: ALU results go straight to the register file, loads
// wait for the memory response, are extended, then written.
module wb_load_unit
   import rv32_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic            ex_wr_en,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_result,
   input  logic            ex_is_load,
   input  logic [2:0]      ex_funct3,
   input  logic [1:0]      ex_addr_lo,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            reg_wr_en,
   output logic [4:0]      write_reg1,
   output logic [XLEN-1:0] write_data,
   output logic            pend_valid,
   output logic [4:0]      pend_rd,
   output logic            load_fault
);

   wb_state_t       state_reg;
   logic [4:0]      ld_rd;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_addr_lo;
   logic            ld_wr_en;
   logic [7:0]      wait_count;
   logic [XLEN-1:0] ext_data;

   load_extend u_load_extend (
      .funct3  (ld_funct3),
      .addr_lo (ld_addr_lo),
      .rdata   (mem_rdata),
      .data    (ext_data)
   );

   assign ex_ready   = (state_reg == IDLE);
   assign pend_valid = (state_reg == LOAD_WAIT);
   assign pend_rd    = pend_valid ? ld_rd : ZERO_REG;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         reg_wr_en  <= 1'b0;
         write_reg1 <= ZERO_REG;
         write_data <= '0;
         load_fault <= 1'b0;
         ld_rd      <= ZERO_REG;
         ld_funct3  <= 3'd0;
         ld_addr_lo <= 2'd0;
         ld_wr_en   <= 1'b0;
         wait_count <= 8'd0;
      end else begin
         reg_wr_en  <= 1'b0;
         load_fault <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (ex_valid) begin
                  if (!ex_is_load) begin
                     if (ex_wr_en && (ex_rd != ZERO_REG)) begin
                        reg_wr_en  <= 1'b1;
                        write_reg1 <= ex_rd;
                        write_data <= ex_result;
                     end
                  end else if (load_rejected(ex_funct3, ex_addr_lo)) begin
                     load_fault <= 1'b1;
                  end else begin
                     ld_rd      <= ex_rd;
                     ld_funct3  <= ex_funct3;
                     ld_addr_lo <= ex_addr_lo;
                     ld_wr_en   <= ex_wr_en;
                     wait_count <= 8'd0;
                     state_reg  <= LOAD_WAIT;
                  end
               end
            end
            LOAD_WAIT: begin
               // A response in the last allowed wait cycle still completes the load.
               if (mem_rvalid) begin
                  if (ld_wr_en && (ld_rd != ZERO_REG)) begin
                     reg_wr_en  <= 1'b1;
                     write_reg1 <= ld_rd;
                     write_data <= ext_data;
                  end
                  state_reg <= IDLE;
               end else if (wait_count == 8'(LOAD_TIMEOUT - 1)) begin
                  load_fault <= 1'b1;
                  wait_count <= 8'd0;
                  state_reg  <= IDLE;
               end else begin
                  wait_count <= wait_count + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_load_unit.sv
// Bench for wb_load_unit: directed vector table, random vectors checked against
// an arithmetic reference model, plus back-to-back and reset-during-load sequences.
module tb_wb_load_unit;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, ex_wr_en, ex_is_load;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result;
   logic [2:0]  ex_funct3;
   logic [1:0]  ex_addr_lo;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        reg_wr_en, pend_valid, load_fault;
   logic [4:0]  write_reg1, pend_rd;
   logic [31:0] write_data;

   int n_pass  = 0;
   int n_total = 0;
   logic [4:0]  hold_reg  = 5'd0;
   logic [31:0] hold_data = 32'd0;

   typedef struct {
      bit        is_load;
      bit        wr_en;
      bit [4:0]  rd;
      bit [31:0] result;
      bit [2:0]  f3;
      bit [1:0]  lo;
      int        wait_n;
      bit        respond;
      bit [31:0] rdata;
      bit        exp_we;
      bit        exp_fault;
      bit [31:0] exp_data;
   } vec_t;

   wb_load_unit #(.XLEN(32), .LOAD_TIMEOUT(TMO)) dut (
      .clock      (clock),
      .reset      (reset),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_wr_en   (ex_wr_en),
      .ex_rd      (ex_rd),
      .ex_result  (ex_result),
      .ex_is_load (ex_is_load),
      .ex_funct3  (ex_funct3),
      .ex_addr_lo (ex_addr_lo),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .reg_wr_en  (reg_wr_en),
      .write_reg1 (write_reg1),
      .write_data (write_data),
      .pend_valid (pend_valid),
      .pend_rd    (pend_rd),
      .load_fault (load_fault)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   function automatic bit load_legal(input bit [2:0] f3, input bit [1:0] lo);
      case (f3)
         3'd0, 3'd4: return 1'b1;
         3'd1, 3'd5: return (lo % 2) == 0;
         3'd2:       return lo == 0;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic bit [31:0] model_ext(input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] w);
      bit [31:0] b, h;
      b = (w >> (8 * int'(lo))) & 32'hFF;
      h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int n_wait;
      chk("idle_ready", {31'd0, ex_ready}, 32'd1);
      ex_valid = 1'b1; ex_is_load = v.is_load; ex_wr_en = v.wr_en; ex_rd = v.rd;
      ex_result = v.result; ex_funct3 = v.f3; ex_addr_lo = v.lo;
      @(posedge clock); #1;
      ex_valid = 1'b0;
      if (v.is_load && load_legal(v.f3, v.lo)) begin
         n_wait = v.respond ? v.wait_n : TMO;
         for (int k = 0; k < n_wait; k++) begin
            chk("wait_pend_valid", {31'd0, pend_valid}, 32'd1);
            chk("wait_pend_rd", {27'd0, pend_rd}, {27'd0, v.rd});
            chk("wait_ex_ready", {31'd0, ex_ready}, 32'd0);
            chk("wait_no_write", {31'd0, reg_wr_en}, 32'd0);
            ex_valid = 1'($urandom_range(0, 1)); ex_is_load = 1'b0; ex_wr_en = 1'b1;
            ex_rd = 5'($urandom_range(1, 31)); ex_result = $urandom;
            mem_rdata = $urandom;
            @(posedge clock); #1;
         end
         if (v.respond) begin
            chk("resp_pend_valid", {31'd0, pend_valid}, 32'd1);
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
            @(posedge clock); #1;
            mem_rvalid = 1'b0; mem_rdata = $urandom;
         end
         ex_valid = 1'b0;
      end
      chk("done_reg_wr_en", {31'd0, reg_wr_en}, {31'd0, v.exp_we});
      chk("done_load_fault", {31'd0, load_fault}, {31'd0, v.exp_fault});
      chk("done_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("done_pend_valid", {31'd0, pend_valid}, 32'd0);
      if (v.exp_we) begin
         hold_reg  = v.rd;
         hold_data = v.exp_data;
      end
      chk("write_reg1", {27'd0, write_reg1}, {27'd0, hold_reg});
      chk("write_data", write_data, hold_data);
      @(posedge clock); #1;
      chk("pulse_wr_en", {31'd0, reg_wr_en}, 32'd0);
      chk("pulse_fault", {31'd0, load_fault}, 32'd0);
      $display("txn %0d load=%0b f3=%0d lo=%0d rd=%0d wait=%0d resp=%0b we=%0b fault=%0b data=%h",
               idx, v.is_load, v.f3, v.lo, v.rd, v.wait_n, v.respond, reg_wr_en, load_fault, write_data);
   endtask

   vec_t vecs[$];
   vec_t rv;
   logic [31:0] r;

   initial begin
      // is_load wr_en rd result f3 lo wait resp rdata | exp_we exp_fault exp_data
      vecs.push_back('{0, 1, 5,  32'hDEADBEEF, 3'd0, 2'd0, 0, 0, 32'h0,        1, 0, 32'hDEADBEEF});
      vecs.push_back('{1, 1, 7,  32'h0,        3'd0, 2'd2, 3, 1, 32'h12F45678, 1, 0, 32'hFFFFFFF4});
      vecs.push_back('{1, 1, 8,  32'h0,        3'd5, 2'd2, 0, 1, 32'h8001ABCD, 1, 0, 32'h00008001});
      vecs.push_back('{1, 1, 9,  32'h0,        3'd1, 2'd2, 1, 1, 32'h8001ABCD, 1, 0, 32'hFFFF8001});
      vecs.push_back('{1, 1, 10, 32'h0,        3'd2, 2'd1, 0, 0, 32'h0,        0, 1, 32'h0});
      vecs.push_back('{1, 1, 10, 32'h0,        3'd3, 2'd0, 0, 0, 32'h0,        0, 1, 32'h0});
      vecs.push_back('{1, 1, 11, 32'h0,        3'd2, 2'd0, 0, 0, 32'h0,        0, 1, 32'h0});
      vecs.push_back('{1, 1, 12, 32'h0,        3'd2, 2'd0, 3, 1, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D});
      vecs.push_back('{1, 1, 0,  32'h0,        3'd0, 2'd0, 1, 1, 32'h00000080, 0, 0, 32'h0});
      vecs.push_back('{0, 1, 0,  32'h11111111, 3'd0, 2'd0, 0, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back('{0, 0, 3,  32'h22222222, 3'd0, 2'd0, 0, 0, 32'h0,        0, 0, 32'h0});
      vecs.push_back('{1, 1, 4,  32'h0,        3'd4, 2'd3, 2, 1, 32'h9A000000, 1, 0, 32'h0000009A});
      vecs.push_back('{1, 1, 6,  32'h0,        3'd1, 2'd3, 0, 0, 32'h0,        0, 1, 32'h0});
      vecs.push_back('{1, 1, 6,  32'h0,        3'd6, 2'd0, 0, 0, 32'h0,        0, 1, 32'h0});

      reset = 1'b1; ex_valid = 1'b0; ex_wr_en = 1'b0; ex_rd = 5'd0; ex_result = 32'd0;
      ex_is_load = 1'b0; ex_funct3 = 3'd0; ex_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      #1;
      chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
      chk("rst_write_reg1", {27'd0, write_reg1}, 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      chk("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
      chk("rst_pend_rd", {27'd0, pend_rd}, 32'd0);
      chk("rst_load_fault", {31'd0, load_fault}, 32'd0);
      #11 reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Back-to-back ALU accepts on consecutive cycles.
      ex_valid = 1'b1; ex_is_load = 1'b0; ex_wr_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         r = $urandom;
         ex_rd = 5'(i + 1); ex_result = r;
         @(posedge clock); #1;
         chk("b2b_wr_en", {31'd0, reg_wr_en}, 32'd1);
         chk("b2b_reg", {27'd0, write_reg1}, i + 1);
         chk("b2b_data", write_data, r);
         chk("b2b_ready", {31'd0, ex_ready}, 32'd1);
         hold_reg = 5'(i + 1); hold_data = r;
         $display("txn b2b %0d rd=%0d data=%h", i, write_reg1, write_data);
      end
      ex_valid = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 60; i++) begin
         rv.is_load = 1'($urandom_range(0, 1));
         rv.wr_en   = ($urandom_range(0, 3) != 0);
         rv.rd      = 5'($urandom_range(0, 31));
         rv.result  = $urandom;
         rv.f3      = 3'($urandom_range(0, 7));
         rv.lo      = 2'($urandom_range(0, 3));
         rv.wait_n  = $urandom_range(0, TMO - 1);
         rv.respond = ($urandom_range(0, 4) != 0);
         rv.rdata   = $urandom;
         rv.exp_fault = 1'b0; rv.exp_we = 1'b0; rv.exp_data = 32'd0;
         if (!rv.is_load) begin
            rv.exp_we = rv.wr_en && (rv.rd != 0);
            rv.exp_data = rv.result;
         end else if (!load_legal(rv.f3, rv.lo) || !rv.respond) begin
            rv.exp_fault = 1'b1;
         end else begin
            rv.exp_we = rv.wr_en && (rv.rd != 0);
            rv.exp_data = model_ext(rv.f3, rv.lo, rv.rdata);
         end
         run_vec(100 + i, rv);
      end

      // Reset while a load is outstanding, then a stray response.
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd13;
      ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
      @(posedge clock); #1;
      ex_valid = 1'b0;
      @(posedge clock); #1;
      chk("midrst_pending", {31'd0, pend_valid}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("midrst_pend_valid", {31'd0, pend_valid}, 32'd0);
      chk("midrst_pend_rd", {27'd0, pend_rd}, 32'd0);
      chk("midrst_write_reg1", {27'd0, write_reg1}, 32'd0);
      chk("midrst_write_data", write_data, 32'd0);
      #2 reset = 1'b0;
      hold_reg = 5'd0; hold_data = 32'd0;
      @(posedge clock); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      chk("stray_no_write", {31'd0, reg_wr_en}, 32'd0);
      chk("stray_no_fault", {31'd0, load_fault}, 32'd0);
      chk("stray_write_data", write_data, 32'd0);
      chk("stray_ready", {31'd0, ex_ready}, 32'd1);
      $display("txn reset-mid-load we=%0b fault=%0b", reg_wr_en, load_fault);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
- Write-back stage of the RV32I core; drives the register file write port (reg_wr_en, write_reg1, write_data).
- Accepts retiring instructions from the execute stage.
  - ALU results are written back directly.
  - Loads wait for the data-memory response, then are aligned and sign- or zero-extended before the write.
- Exposes the in-flight destination register to decode for hazard stalls, and reports load faults.

Parameters:
- XLEN, 32, data width (fixed at 32 for RV32I; do not override).
- LOAD_TIMEOUT, 15, maximum cycles spent in LOAD_WAIT before a fault is raised; range 1..255.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  this block accepts the instruction this cycle.
- ex_wr_en  in  1  instruction writes rd.
- ex_rd  in  5  destination register.
- ex_result  in  32  ALU result, used for non-loads.
- ex_is_load  in  1  instruction is a load.
- ex_funct3  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- ex_addr_lo  in  2  low two bits of the load address.
- mem_rvalid  in  1  data memory response valid.
- mem_rdata  in  32  data memory word, aligned to the word address.
- reg_wr_en  out  1  register file write enable.
- write_reg1  out  5  register file write register.
- write_data  out  32  register file write data.
- pend_valid  out  1  a load is outstanding.
- pend_rd  out  5  rd of the outstanding load.
- load_fault  out  1  one-cycle pulse: misaligned, illegal or timed-out load.

Behaviour:
- Reset values (asynchronous, active-high): state=IDLE; all outputs 0 except ex_ready=1; timeout counter=0.
- Handshake: an instruction transfers on a cycle where ex_valid && ex_ready. ex_ready=1 only in IDLE (combinational from state).
- States: IDLE, LOAD_WAIT.
- IDLE, accept non-load:
  - Next cycle: reg_wr_en = ex_wr_en && (ex_rd != 0), write_reg1=ex_rd, write_data=ex_result.
  - Latency 1; back-to-back accepts every cycle are allowed.
- IDLE, accept load:
  - Check alignment and type.
  - Misaligned (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0) or illegal funct3 (011, 110, 111): load_fault=1 next cycle, no write, stay in IDLE.
  - Otherwise: latch rd, funct3, addr_lo and wr_en; go to LOAD_WAIT; counter=0.
- LOAD_WAIT: pend_valid=1 and pend_rd=latched rd; ex_ready=0.
- LOAD_WAIT, mem_rvalid=1:
  - Extract the field: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16].
  - Extend: sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word unmodified.
  - Next cycle: reg_wr_en = latched wr_en && rd!=0, with the extended data; return to IDLE.
  - Total load latency: 1 cycle after the mem_rvalid cycle.
- LOAD_WAIT, no response: counter increments each cycle without mem_rvalid. On the cycle the counter reaches LOAD_TIMEOUT with no mem_rvalid: load_fault=1 next cycle, no write, return to IDLE.
- Timeout boundary: mem_rvalid on the same cycle the counter hits LOAD_TIMEOUT is a success; the response wins.
- mem_rvalid while in IDLE: ignored (late or spurious); no write, no fault.
- reg_wr_en, load_fault and the write outputs are registered single-cycle pulses. write_reg1 and write_data hold their last value when reg_wr_en=0.
- rd=x0: a write is never issued. The instruction still completes, and a load still waits for its response.
- Reset mid-LOAD_WAIT: the outstanding load is abandoned, no write occurs, and a later mem_rvalid is ignored.

Decomposition:
- Shared package rv32_pkg:
  - funct3 load encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_t enum {IDLE, LOAD_WAIT}.
  - Constant ZERO_REG = 5'd0.
- One sub-module: load_extend — combinational (funct3, addr_lo, rdata) -> 32-bit extended data; reused by any later cache path.

Test Plan:
- Reset, then a non-load: ex_valid=1, rd=5, result=0xDEADBEEF -> next cycle reg_wr_en=1, write_reg1=5, write_data=0xDEADBEEF; ex_ready stays 1.
- LB with addr_lo=2, after 3 wait cycles mem_rdata=0x12F45678 -> pend_valid=1 and pend_rd=rd for 3 cycles, ex_ready=0; then write_data=0xFFFFFFF4.
- LHU with addr_lo=2, mem_rdata=0x8001ABCD -> write_data=0x00008001. LH on the same data -> 0xFFFF8001.
- LW with addr_lo=1 -> load_fault pulse next cycle, no reg_wr_en, ex_ready=1 throughout. funct3=011 gives the same result.
- LW with LOAD_TIMEOUT=4 and no mem_rvalid -> load_fault after the timeout, no write, back to IDLE. Repeat with mem_rvalid exactly on the timeout cycle -> write occurs and no fault.
- Load to rd=0 and ALU op to rd=0 -> never reg_wr_en. Reset asserted mid-LOAD_WAIT, then mem_rvalid -> no write, outputs at reset values.
